// File: rtl/osc_phase_reader.sv
// Receive-side decoder for a 5-phase ring oscillator: synchronizes the phases, decodes a 10-sector
// position and reports sectors advanced per window. Optional OSC_PHASE_READER_GLITCH_FILT_EN.
module osc_phase_reader #(
  parameter int unsigned WIN_LOG2 = 10,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [4:0]       ph_in,
  output logic [3:0]       sector,
  output logic             sector_vld,
  output logic [CNT_W-1:0] meas_cnt,
  output logic             meas_vld,
  output logic             meas_ovf,
  output logic             err_code,
  output logic             err_skip,
  output logic [7:0]       err_cnt
);

  localparam logic [3:0] MaxStep = 4'(MAX_STEP);

  typedef enum logic [1:0] {StIdle, StAcq, StTrack} state_e;

  state_e               state_q, state_d;
  logic [4:0]           sync1_q, sync2_q;
  logic [3:0]           sector_q, sector_d;
  logic                 sector_vld_q, sector_vld_d;
  logic [CNT_W-1:0]     acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [WIN_LOG2-1:0]  win_q, win_d;
  logic [CNT_W-1:0]     meas_cnt_q, meas_cnt_d;
  logic                 meas_vld_q, meas_vld_d;
  logic                 meas_ovf_q, meas_ovf_d;
  logic                 err_code_q, err_code_d;
  logic                 err_skip_q, err_skip_d;
  logic [7:0]           err_cnt_q, err_cnt_d;

  logic [4:0]           smp;
  logic                 smp_ok;
  logic [4:0]           dec;
  logic [4:0]           diff, diff_m;
  logic [3:0]           delta, add_amt;
  logic                 step_ok, skip;
  logic [CNT_W:0]       sum;
  logic                 sat;
  logic [CNT_W-1:0]     acc_sum;

  function automatic logic [4:0] decode(input logic [4:0] c);
    logic [4:0] r;
    case (c)
      5'b11001: r = {1'b1, 4'd0};
      5'b10001: r = {1'b1, 4'd1};
      5'b10011: r = {1'b1, 4'd2};
      5'b00011: r = {1'b1, 4'd3};
      5'b00111: r = {1'b1, 4'd4};
      5'b00110: r = {1'b1, 4'd5};
      5'b01110: r = {1'b1, 4'd6};
      5'b01100: r = {1'b1, 4'd7};
      5'b11100: r = {1'b1, 4'd8};
      5'b11000: r = {1'b1, 4'd9};
      default:  r = 5'b0;
    endcase
    return r;
  endfunction

`ifdef OSC_PHASE_READER_GLITCH_FILT_EN
  logic [4:0] samp_q;
  // Decode the previous sample only when the newer one agrees with it.
  assign smp    = samp_q;
  assign smp_ok = (samp_q == sync2_q);
`else
  assign smp    = sync2_q;
  assign smp_ok = 1'b1;
`endif

  always_comb begin
    dec     = decode(smp);
    diff    = {1'b0, dec[3:0]} + 5'd10 - {1'b0, sector_q};
    diff_m  = diff - 5'd10;
    delta   = (diff >= 5'd10) ? diff_m[3:0] : diff[3:0];
    step_ok = (delta != 4'd0) && (delta <= MaxStep);
    skip    = (delta != 4'd0) && !step_ok;
    add_amt = ((state_q == StTrack) && en && smp_ok && dec[4] && step_ok) ? delta : 4'd0;
    sum     = {1'b0, acc_q} + {{(CNT_W-3){1'b0}}, add_amt};
    sat     = sum[CNT_W];
    acc_sum = sat ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    sector_d     = sector_q;
    sector_vld_d = sector_vld_q;
    acc_d        = acc_q;
    ovf_d        = ovf_q;
    win_d        = win_q;
    meas_cnt_d   = meas_cnt_q;
    meas_vld_d   = 1'b0;
    meas_ovf_d   = meas_ovf_q;
    err_code_d   = 1'b0;
    err_skip_d   = 1'b0;

    case (state_q)
      StIdle: begin
        acc_d        = '0;
        ovf_d        = 1'b0;
        win_d        = '0;
        sector_vld_d = 1'b0;
        if (en) state_d = StAcq;
      end
      StAcq: begin
        if (!en) begin
          state_d = StIdle;
        end else if (smp_ok) begin
          if (dec[4]) begin
            sector_d     = dec[3:0];
            sector_vld_d = 1'b1;
            state_d      = StTrack;
            win_d        = '0;
            acc_d        = '0;
            ovf_d        = 1'b0;
          end else begin
            err_code_d = 1'b1;
          end
        end
      end
      StTrack: begin
        if (!en) begin
          // Partial window is dropped without a report.
          state_d      = StIdle;
          sector_vld_d = 1'b0;
          acc_d        = '0;
          ovf_d        = 1'b0;
          win_d        = '0;
        end else begin
          win_d = win_q + {{(WIN_LOG2-1){1'b0}}, 1'b1};
          if (smp_ok) begin
            if (!dec[4]) begin
              err_code_d = 1'b1;
            end else begin
              sector_d   = dec[3:0];
              err_skip_d = skip;
            end
          end
          if (win_q == {WIN_LOG2{1'b1}}) begin
            meas_cnt_d = acc_sum;
            meas_vld_d = 1'b1;
            meas_ovf_d = ovf_q | sat;
            acc_d      = '0;
            ovf_d      = 1'b0;
          end else begin
            acc_d = acc_sum;
            ovf_d = ovf_q | sat;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    err_cnt_d = err_cnt_q;
    if ((err_code_d || err_skip_d) && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      state_q      <= StIdle;
      sector_q     <= '0;
      sector_vld_q <= 1'b0;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      win_q        <= '0;
      meas_cnt_q   <= '0;
      meas_vld_q   <= 1'b0;
      meas_ovf_q   <= 1'b0;
      err_code_q   <= 1'b0;
      err_skip_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      sync1_q      <= ph_in;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      sector_q     <= sector_d;
      sector_vld_q <= sector_vld_d;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      win_q        <= win_d;
      meas_cnt_q   <= meas_cnt_d;
      meas_vld_q   <= meas_vld_d;
      meas_ovf_q   <= meas_ovf_d;
      err_code_q   <= err_code_d;
      err_skip_q   <= err_skip_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

`ifdef OSC_PHASE_READER_GLITCH_FILT_EN
  always_ff @(posedge clk) begin
    if (rst) samp_q <= '0;
    else     samp_q <= sync2_q;
  end
`endif

  assign sector     = sector_q;
  assign sector_vld = sector_vld_q;
  assign meas_cnt   = meas_cnt_q;
  assign meas_vld   = meas_vld_q;
  assign meas_ovf   = meas_ovf_q;
  assign err_code   = err_code_q;
  assign err_skip   = err_skip_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_osc_phase_reader.sv
// Directed bench for osc_phase_reader: two instances (wide counter / MAX_STEP 4 and
// 4-bit counter / MAX_STEP 1) share one phase driver.
module tb_osc_phase_reader;

  logic clk = 1'b0;
  logic rst, en;
  logic [4:0] ph_in;

  logic [3:0]  sector_a, sector_b;
  logic        sector_vld_a, sector_vld_b;
  logic [15:0] meas_cnt_a;
  logic [3:0]  meas_cnt_b;
  logic        meas_vld_a, meas_vld_b, meas_ovf_a, meas_ovf_b;
  logic        err_code_a, err_code_b, err_skip_a, err_skip_b;
  logic [7:0]  err_cnt_a, err_cnt_b;

  osc_phase_reader #(.WIN_LOG2(6), .CNT_W(16), .MAX_STEP(4)) dut_a (
    .clk(clk), .rst(rst), .en(en), .ph_in(ph_in),
    .sector(sector_a), .sector_vld(sector_vld_a), .meas_cnt(meas_cnt_a),
    .meas_vld(meas_vld_a), .meas_ovf(meas_ovf_a), .err_code(err_code_a),
    .err_skip(err_skip_a), .err_cnt(err_cnt_a)
  );

  osc_phase_reader #(.WIN_LOG2(6), .CNT_W(4), .MAX_STEP(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .ph_in(ph_in),
    .sector(sector_b), .sector_vld(sector_vld_b), .meas_cnt(meas_cnt_b),
    .meas_vld(meas_vld_b), .meas_ovf(meas_ovf_b), .err_code(err_code_b),
    .err_skip(err_skip_b), .err_cnt(err_cnt_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vld_n, gap, last_vld_cyc;
  int last_meas_a, last_ovf_a, last_meas_b, last_ovf_b;
  int ec_a, es_a, es_b;
  int drv_sec, drv_step, drv_div, div_cnt;
  int n, s;

  function automatic logic [4:0] code(input int sec);
    case (sec)
      0: return 5'b11001;
      1: return 5'b10001;
      2: return 5'b10011;
      3: return 5'b00011;
      4: return 5'b00111;
      5: return 5'b00110;
      6: return 5'b01110;
      7: return 5'b01100;
      8: return 5'b11100;
      9: return 5'b11000;
      default: return 5'b10101;
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: observe outputs just after the edge, then advance the phase driver.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (meas_vld_a) begin
      vld_n++;
      gap = cyc - last_vld_cyc;
      last_vld_cyc = cyc;
      last_meas_a = int'(meas_cnt_a);
      last_ovf_a = int'(meas_ovf_a);
    end
    if (meas_vld_b) begin
      last_meas_b = int'(meas_cnt_b);
      last_ovf_b = int'(meas_ovf_b);
    end
    ec_a += int'(err_code_a);
    es_a += int'(err_skip_a);
    es_b += int'(err_skip_b);
    if (drv_div != 0) begin
      div_cnt++;
      if (div_cnt >= drv_div) begin
        div_cnt = 0;
        drv_sec = (drv_sec + drv_step) % 10;
        ph_in = code(drv_sec);
      end
    end
  endtask

  task automatic clr_obs();
    vld_n = 0;
    gap = 0;
    last_vld_cyc = cyc;
    ec_a = 0;
    es_a = 0;
    es_b = 0;
  endtask

  task automatic wait_vld(input int budget, input string tag, output int cnt);
    int start;
    start = vld_n;
    cnt = 0;
    while (vld_n == start && cnt < budget) begin
      tick();
      cnt++;
    end
    chk(tag, int'(vld_n != start), 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sector"}, int'(sector_a), 0);
    chk({tag, "_sector_vld"}, int'(sector_vld_a), 0);
    chk({tag, "_meas_cnt"}, int'(meas_cnt_a), 0);
    chk({tag, "_meas_vld"}, int'(meas_vld_a), 0);
    chk({tag, "_meas_ovf"}, int'(meas_ovf_a), 0);
    chk({tag, "_err_code"}, int'(err_code_a), 0);
    chk({tag, "_err_skip"}, int'(err_skip_a), 0);
    chk({tag, "_err_cnt"}, int'(err_cnt_a), 0);
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    drv_sec = 0;
    drv_step = 1;
    drv_div = 0;
    div_cnt = 0;
    ph_in = code(0);
    last_meas_a = -1;
    last_ovf_a = -1;
    last_meas_b = -1;
    last_ovf_b = -1;
    clr_obs();
    tick();
    tick();
    chk_reset("reset");

    // 1 sector per 4 clk.
    rst = 1'b0;
    repeat (5) tick();
    en = 1'b1;
    drv_div = 4;
    repeat (200) tick();
    chk("acq_sector_vld", int'(sector_vld_a), 1);
    clr_obs();
    repeat (128) tick();
    chk("slow_vld_n", vld_n, 2);
    chk("slow_gap", gap, 64);
    chk("slow_meas", last_meas_a, 16);
    chk("slow_ovf", last_ovf_a, 0);
    chk("slow_err_code", ec_a, 0);
    chk("slow_err_skip", es_a, 0);
    chk("slow_meas_b_sat", last_meas_b, 15);
    chk("slow_ovf_b", last_ovf_b, 1);
    chk("slow_err_skip_b", es_b, 0);

    // 2 sectors per clk.
    drv_div = 1;
    drv_step = 2;
    div_cnt = 0;
    repeat (100) tick();
    clr_obs();
    repeat (128) tick();
    chk("fast_vld_n", vld_n, 2);
    chk("fast_meas", last_meas_a, 128);
    chk("fast_err_skip", es_a, 0);
    chk("fast_err_cnt", int'(err_cnt_a), 0);
    chk("fast_meas_b", last_meas_b, 0);
    chk("fast_ovf_b", last_ovf_b, 0);
    chk("fast_err_skip_b", es_b, 128);

    // One-clock illegal code while parked.
    drv_div = 0;
    repeat (6) tick();
    s = drv_sec;
    chk("park_sector", int'(sector_a), s);
    ph_in = 5'b10101;
    tick();
    ph_in = code(s);
    tick();
    chk("glitch_early", int'(err_code_a), 0);
    tick();
    chk("glitch_err_code", int'(err_code_a), 1);
    chk("glitch_sector_held", int'(sector_a), s);
    tick();
    chk("glitch_pulse_end", int'(err_code_a), 0);
    chk("glitch_err_cnt", int'(err_cnt_a), 1);

    // Walk forward to 3, then step back to 2.
    while (drv_sec != 3) begin
      drv_sec = (drv_sec + 1) % 10;
      ph_in = code(drv_sec);
      tick();
      tick();
    end
    repeat (4) tick();
    chk("back_pre_sector", int'(sector_a), 3);
    drv_sec = 2;
    ph_in = code(2);
    tick();
    tick();
    chk("back_early", int'(err_skip_a), 0);
    tick();
    chk("back_err_skip", int'(err_skip_a), 1);
    chk("back_sector", int'(sector_a), 2);
    chk("back_err_cnt", int'(err_cnt_a), 2);

    // Continuous backward stepping saturates err_cnt.
    drv_div = 1;
    drv_step = 9;
    div_cnt = 0;
    clr_obs();
    repeat (300) tick();
    chk("back_run_err_cnt", int'(err_cnt_a), 255);
    chk("back_run_meas", last_meas_a, 0);
    chk("back_run_vld_n", vld_n, 4);
    drv_div = 0;
    repeat (10) tick();
    chk("err_cnt_held", int'(err_cnt_a), 255);

    // Reset in the middle of a window.
    drv_div = 1;
    drv_step = 1;
    div_cnt = 0;
    wait_vld(100, "pre_rst_vld", n);
    repeat (30) tick();
    rst = 1'b1;
    tick();
    chk_reset("midrst");
    rst = 1'b0;
    en = 1'b0;
    clr_obs();
    repeat (100) tick();
    chk("rst_no_vld", vld_n, 0);
    chk("rst_sector_vld", int'(sector_vld_a), 0);

    en = 1'b1;
    wait_vld(200, "rst_first_vld", n);
    chk("rst_first_len", n, 66);
    chk("rst_first_meas", last_meas_a, 64);
    chk("rst_first_meas_b", last_meas_b, 15);
    chk("rst_first_ovf_b", last_ovf_b, 1);

    // Drop enable mid-window.
    repeat (30) tick();
    en = 1'b0;
    clr_obs();
    repeat (100) tick();
    chk("en_no_vld", vld_n, 0);
    chk("en_sector_vld", int'(sector_vld_a), 0);
    en = 1'b1;
    wait_vld(200, "en_first_vld", n);
    chk("en_first_len", n, 66);
    chk("en_first_meas", last_meas_a, 64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/osc_phase_reader.md
Name: osc_phase_reader

Overview:
- Synthesizable receive-side companion to the 5-phase behavioural oscillator model (phases A..E; phase i high over [0.2i, 0.2i+0.5) of the period).
- Samples the five phase outputs on a system clock and decodes them into a 10-sector phase position.
- Tracks forward phase progress and reports sectors advanced per fixed measurement window, i.e. oscillator frequency relative to clk.
- Sits between the oscillator (model or silicon) and the digital control or calibration loop that drives ctrl.

Parameters:
- WIN_LOG2, 10, measurement window length = 2^WIN_LOG2 clk cycles (legal 4..20).
- CNT_W, 16, width of the sector accumulator and meas_cnt.
- MAX_STEP, 4, largest forward sector step accepted per sample (legal 1..4).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  enable; low forces IDLE.
- ph_in  in  5  asynchronous oscillator phases; bit0=A .. bit4=E.
- sector  out  4  current decoded sector 0..9.
- sector_vld  out  1  high while sector holds a valid decode (ACQ and TRACK after first valid code).
- meas_cnt  out  CNT_W  sectors advanced in the last completed window.
- meas_vld  out  1  one-cycle pulse when meas_cnt updates.
- meas_ovf  out  1  accumulator saturated in the reported window; updates with meas_vld.
- err_code  out  1  one-cycle pulse: illegal phase code sampled.
- err_skip  out  1  one-cycle pulse: step of 0 < delta and delta > MAX_STEP (mod 10).
- err_cnt  out  8  saturating error total; cleared only by rst.

Behaviour:
- Input path: ph_in passes through a 2-flop synchronizer per bit, then a decode register. Sector reflects ph_in 3 clk later.
- Decode table (code edcba -> sector): 11001->0, 10001->1, 10011->2, 00011->3, 00111->4, 00110->5, 01110->6, 01100->7, 11100->8, 11000->9. All other 22 codes are illegal.
- Illegal code:
  - err_code pulses.
  - sector holds its previous value.
  - No accumulation that cycle.
- Delta = (new - old) mod 10, computed only between consecutive legal samples:
  - delta 0: no change.
  - 1..MAX_STEP: accumulate delta.
  - Any other value: err_skip pulses, no accumulation, sector still updates to the new value.
- States:
  - IDLE: reset state and whenever en=0. Accumulator and window counter are 0; sector_vld=0.
  - ACQ: entered from IDLE when en=1. Waits for the first legal code, loads sector, sets sector_vld, then moves to TRACK. No accumulation in ACQ.
  - TRACK: window counter runs 0..2^WIN_LOG2-1, starting at 0 on the cycle after entry. On the cycle the counter equals the terminal value:
    - meas_cnt <= acc + that cycle's delta, saturated.
    - meas_vld=1; meas_ovf is set if saturation occurred anywhere in the window.
    - acc <= 0; counter wraps to 0.
  - en falling in TRACK goes to IDLE on the next cycle. The partial window is discarded and meas_vld does not pulse.
- Accumulator saturates at 2^CNT_W-1 and does not wrap.
- Simultaneous error and window end: the window reports with the erroring sample contributing 0.
- err_cnt increments by 1 per err_code or err_skip pulse and sticks at 255. err_code and err_skip are mutually exclusive.
- Reset values: sector=0, sector_vld=0, meas_cnt=0, meas_vld=0, meas_ovf=0, err_code=0, err_skip=0, err_cnt=0. Synchronizer flops and state are cleared as well (state=IDLE).
- rst mid-window: all state cleared next edge, no meas_vld pulse.

Optional Feature:
- Macro: OSC_PHASE_READER_GLITCH_FILT_EN.
- Defined:
  - A synchronized code must be identical on 2 consecutive samples before it is decoded.
  - Unstable samples are ignored, with no err_code and no accumulation.
  - Sector latency becomes 4 clk.
- Undefined: every synchronized sample is decoded with 3 clk latency.

Test Plan:
- WIN_LOG2=6, phase driver advances one sector every 4 clk, en=1 -> ACQ then TRACK; every steady-state window gives meas_cnt=16, meas_vld once per 64 clk, no errors.
- Driver advances 2 sectors/clk, WIN_LOG2=6 -> meas_cnt=128; MAX_STEP=1 with the same stimulus -> err_skip every legal sample, meas_cnt=0.
- Force ph_in=10101 for 1 clk (filter off) -> err_code pulse 3 clk later, sector held, err_cnt=1; with GLITCH_FILT_EN defined -> no err_code.
- Backward step 3->2 -> err_skip (delta=9), sector=2, no accumulation; 300 such errors -> err_cnt=255, held.
- CNT_W=4, 1 sector/clk, WIN_LOG2=6 -> meas_cnt=15, meas_ovf=1.
- Assert rst at window clk 30, or drop en -> no meas_vld for that window; all outputs at reset values; after re-enable the first window is full length.
